// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 4:16 decoder.
package decoder_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    logic [15:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder4_16_seq_dec4_16.sv
// Combinational 4->16 one-hot lookup feeding the next-Y register.
module dec4_16
  import decoder_pkg::*;
(
  input  logic [3:0]  l,
  output logic [15:0] y
);

  always_comb begin
    y = onehot16(l);
  end

endmodule

// File: rtl/decoder4_16_seq.sv
// Timed one-hot strobe generator: accepts an encoded index and drives Y=1<<L for HOLD
// cycles, followed by GAP idle cycles, with a ready handshake and completed-symbol counter.
module decoder4_16_seq
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EI1,
  input  logic [3:0]    L,
  input  logic          GS,
  output logic          rdy,
  output logic [15:0]   Y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sym_cnt
);

  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("decoder4_16_seq: HOLD must be in 1..255");
  end
  if (GAP > 255) begin : g_bad_gap
    $error("decoder4_16_seq: GAP must be in 0..255");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP == 0) ? '0 : CNT_W'(GAP - 1);
  localparam logic             NO_GAP  = (GAP == 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW-1:0]     sym_cnt_q, sym_cnt_d;
  logic [15:0]       y_new;
  logic              cnt_zero;
  logic              accept;

  dec4_16 u_dec (
    .l (L),
    .y (y_new)
  );

  always_comb begin
    cnt_zero = (cnt_q == '0);
    rdy = EI1 & ((state_q == decoder_pkg::IDLE)
               | ((state_q == decoder_pkg::DRIVE) & cnt_zero & NO_GAP)
               | ((state_q == decoder_pkg::GAP) & cnt_zero));
    accept = EI1 & GS & rdy;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    sym_cnt_d = sym_cnt_q;
    if (!EI1) begin
      // Enable loss aborts the symbol in flight without counting it.
      state_d = decoder_pkg::IDLE;
      cnt_d   = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        decoder_pkg::IDLE: begin
          y_d = '0;
          if (accept) begin
            state_d = decoder_pkg::DRIVE;
            y_d     = y_new;
            cnt_d   = HOLD_LD;
          end
        end
        decoder_pkg::DRIVE: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            sym_cnt_d = sym_cnt_q + CW'(1);
            if (!NO_GAP) begin
              state_d = decoder_pkg::GAP;
              y_d     = '0;
              cnt_d   = GAP_LD;
            end else if (accept) begin
              y_d   = y_new;
              cnt_d = HOLD_LD;
            end else begin
              state_d = decoder_pkg::IDLE;
              y_d     = '0;
            end
          end
        end
        decoder_pkg::GAP: begin
          y_d = '0;
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (accept) begin
            state_d = decoder_pkg::DRIVE;
            y_d     = y_new;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = decoder_pkg::IDLE;
          end
        end
        default: begin
          state_d = decoder_pkg::IDLE;
          cnt_d   = '0;
          y_d     = '0;
        end
      endcase
    end
    busy_d = (state_d != decoder_pkg::IDLE);
    // done marks the cycle in which the final DRIVE count is on the register.
    done_d = (state_d == decoder_pkg::DRIVE) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= decoder_pkg::IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign Y       = y_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sym_cnt = sym_cnt_q;

endmodule

// File: tb/tb_decoder4_16_seq.sv
// Bench for decoder4_16_seq: two instances (HOLD=4/GAP=1/CW=8 and HOLD=4/GAP=0/CW=4)
// checked against a symbol-timeline reference model plus vector tables.
module tb_decoder4_16_seq;

  logic        clk;
  logic        rst;
  logic        ei [2];
  logic        gs [2];
  logic [3:0]  l  [2];
  logic        rdy [2];
  logic [15:0] y  [2];
  logic        busy [2];
  logic        done [2];
  logic [7:0]  sym_a;
  logic [3:0]  sym_b;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: each instance is a timeline of symbols; pos counts cycles since accept.
  int unsigned hold_j [2] = '{4, 4};
  int unsigned gap_j  [2] = '{1, 0};
  int unsigned mask_j [2] = '{255, 15};
  bit          m_act  [2];
  int unsigned m_pos  [2];
  int unsigned m_code [2];
  int unsigned m_cnt  [2];

  decoder4_16_seq #(.HOLD(4), .GAP(1), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .EI1(ei[0]), .L(l[0]), .GS(gs[0]),
    .rdy(rdy[0]), .Y(y[0]), .busy(busy[0]), .done(done[0]), .sym_cnt(sym_a)
  );

  decoder4_16_seq #(.HOLD(4), .GAP(0), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .EI1(ei[1]), .L(l[1]), .GS(gs[1]),
    .rdy(rdy[1]), .Y(y[1]), .busy(busy[1]), .done(done[1]), .sym_cnt(sym_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] sym_of(input int j);
    return (j == 0) ? {24'd0, sym_a} : {28'd0, sym_b};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_act[j] = 0; m_pos[j] = 0; m_code[j] = 0; m_cnt[j] = 0;
    end
  endtask

  // One clock: check rdy on settled inputs, advance model at the edge, check outputs after it.
  task automatic tick();
    bit          exp_rdy;
    logic [15:0] exp_y;
    #1;
    for (int j = 0; j < 2; j++) begin
      exp_rdy = ei[j] && (!m_act[j] || m_pos[j] == hold_j[j] + gap_j[j] - 1);
      chk($sformatf("rdy[%0d]", j), 32'(rdy[j]), 32'(exp_rdy));
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (!ei[j]) begin
        m_act[j] = 0;
      end else begin
        if (m_act[j] && m_pos[j] == hold_j[j] - 1) m_cnt[j]++;
        if (!m_act[j] || m_pos[j] == hold_j[j] + gap_j[j] - 1) begin
          if (gs[j]) begin
            m_act[j] = 1; m_pos[j] = 0; m_code[j] = l[j];
          end else begin
            m_act[j] = 0;
          end
        end else begin
          m_pos[j]++;
        end
      end
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      exp_y = (m_act[j] && m_pos[j] < hold_j[j]) ? (16'd1 << m_code[j]) : 16'd0;
      chk($sformatf("Y[%0d]", j), 32'(y[j]), 32'(exp_y));
      chk($sformatf("busy[%0d]", j), 32'(busy[j]), 32'(m_act[j]));
      chk($sformatf("done[%0d]", j), 32'(done[j]),
          32'(m_act[j] && m_pos[j] == hold_j[j] - 1));
      chk($sformatf("sym_cnt[%0d]", j), sym_of(j), m_cnt[j] & mask_j[j]);
    end
  endtask

  task automatic set_in(input int j, input logic e, input logic g, input logic [3:0] v);
    ei[j] = e; gs[j] = g; l[j] = v;
  endtask

  typedef struct {
    logic        ei;
    logic        gs;
    logic [3:0]  l;
    logic        rdy;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [7:0]  sym;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] base;

  initial begin
    rst = 1'b1;
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b1, 4'd5);
    model_reset();

    // Reset holds everything clear even with a valid request present.
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst Y[%0d]", j), 32'(y[j]), 32'd0);
      chk($sformatf("rst done[%0d]", j), 32'(done[j]), 32'd0);
      chk($sformatf("rst busy[%0d]", j), 32'(busy[j]), 32'd0);
      chk($sformatf("rst sym[%0d]", j), sym_of(j), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b0, 4'd5);
    #1;
    chk("post-rst rdy[0]", 32'(rdy[0]), 32'd1);
    chk("post-rst rdy[1]", 32'(rdy[1]), 32'd1);

    // Single symbol L=F on the GAP=1 instance: entry i is applied before edge t0+i.
    tbl[0] = '{1'b1, 1'b1, 4'hF, 1'b1, 16'h8000, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 4'h3, 1'b0, 16'h8000, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 4'h3, 1'b0, 16'h8000, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 1'b0, 4'h3, 1'b0, 16'h8000, 1'b1, 1'b1, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 4'h3, 1'b0, 16'h0000, 1'b1, 1'b0, 8'd1};
    tbl[5] = '{1'b1, 1'b0, 4'h3, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd1};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 2; j++) set_in(j, tbl[i].ei, tbl[i].gs, tbl[i].l);
      #1;
      chk($sformatf("tbl%0d rdy", i), 32'(rdy[0]), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("tbl%0d Y", i), 32'(y[0]), 32'(tbl[i].y));
      chk($sformatf("tbl%0d busy", i), 32'(busy[0]), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d done", i), 32'(done[0]), 32'(tbl[i].done));
      chk($sformatf("tbl%0d sym", i), 32'(sym_a), 32'(tbl[i].sym));
    end

    // Back-to-back symbols on the GAP=0 instance: no zero cycle between L=2 and L=13.
    repeat (3) tick();
    base = sym_of(1);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b1, (i == 0) ? 4'd2 : 4'd13);
      tick();
      chk($sformatf("b2b Y%0d", i), 32'(y[1]), (i < 4) ? 32'h0004 : 32'h2000);
    end
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b0, 4'd0);
    tick();
    chk("b2b sym", sym_of(1), (base + 32'd2) & 32'hF);

    // Enable dropped after two DRIVE cycles of L=7.
    repeat (6) tick();
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b1, 4'd7);
    tick();
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b0, 4'd7);
    tick();
    chk("abort pre Y", 32'(y[0]), 32'h0080);
    base = sym_of(0);
    for (int j = 0; j < 2; j++) set_in(j, 1'b0, 1'b1, 4'd7);
    #1;
    chk("abort rdy", 32'(rdy[0]), 32'd0);
    tick();
    chk("abort Y", 32'(y[0]), 32'd0);
    chk("abort done", 32'(done[0]), 32'd0);
    chk("abort sym", sym_of(0), base);
    for (int j = 0; j < 2; j++) set_in(j, 1'b0, 1'b1, 4'd3);
    tick();
    chk("abort hold Y", 32'(y[0]), 32'd0);

    // GS low blocks acceptance regardless of L.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b0, 4'(i * 5));
      tick();
      chk($sformatf("gs0 Y%0d", i), 32'(y[0] | y[1]), 32'd0);
    end

    // Asynchronous reset between edges clears outputs without a clock.
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b1, 4'd9);
    tick();
    for (int j = 0; j < 2; j++) set_in(j, 1'b1, 1'b0, 4'd9);
    tick();
    chk("pre-arst Y", 32'(y[0]), 32'h0200);
    #1;
    rst = 1'b1;
    #1;
    chk("arst Y[0]", 32'(y[0]), 32'd0);
    chk("arst busy[0]", 32'(busy[0]), 32'd0);
    chk("arst Y[1]", 32'(y[1]), 32'd0);
    chk("arst busy[1]", 32'(busy[1]), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Sweep L=0..15 one instance at a time; CW=4 counter wraps back to 0.
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 16; k++) begin
        set_in(j, 1'b1, 1'b1, 4'(k));
        tick();
        chk($sformatf("sweep%0d Y L=%0d", j, k), 32'(y[j]), 32'(16'd1 << k));
        repeat (hold_j[j] + gap_j[j] - 1) tick();
      end
      set_in(j, 1'b1, 1'b0, 4'd0);
      repeat (hold_j[j] + gap_j[j]) tick();
    end
    chk("sweep sym CW=8", sym_of(0), 32'd16);
    chk("sweep sym CW=4 wrap", sym_of(1), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 2; j++)
        set_in(j, ($urandom % 12) != 0, ($urandom % 3) != 0, 4'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
